// File: rtl/block_lock_ctrl.sv
// block_lock_ctrl: sequences the 66b header seeker and the block extractor.
// It restarts the seeker and lets it settle, then freezes its block offset.
// It verifies headers at that offset, declares lock, and watches a sliding
// bad-header window. On lock loss it forces a full re-search.
module block_lock_ctrl #(
  parameter int RST_CYCLES  = 4,
  parameter int SETTLE_HDRS = 64,
  parameter int LOCK_GOOD   = 32,
  parameter int WIN_SIZE    = 64,
  parameter int BAD_MAX     = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] seek_offset_i,
  input  logic [1:0] hdr_i,
  input  logic       hdr_dv_i,
  input  logic       relock_req_i,
  output logic       seeker_rst_o,
  output logic [6:0] offset_o,
  output logic       offset_vld_o,
  output logic       locked_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int HW = $clog2(SETTLE_HDRS + 1);
  localparam int GW = $clog2(LOCK_GOOD + 1);
  localparam int WW = $clog2(WIN_SIZE + 1);
  localparam int BW = $clog2(BAD_MAX + 1);

  // Each counter fires on the cycle its count would reach the limit, so it
  // compares against limit-1 and never holds a value above it.
  localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
  localparam logic [HW-1:0] SETTLE_LAST = HW'(SETTLE_HDRS - 1);
  localparam logic [GW-1:0] GOOD_LAST   = GW'(LOCK_GOOD - 1);
  localparam logic [WW-1:0] WIN_LAST    = WW'(WIN_SIZE - 1);
  localparam logic [BW-1:0] BAD_LAST    = BW'(BAD_MAX - 1);
  localparam logic [6:0]    OFFSET_MAX  = 7'd65;

  typedef enum logic [1:0] {
    ST_RESTART,
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [HW-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [GW-1:0]   good_cnt_q, good_cnt_d;
  logic [WW-1:0]   win_cnt_q, win_cnt_d;
  logic [BW-1:0]   bad_cnt_q, bad_cnt_d;
  logic            seeker_rst_q, seeker_rst_d;
  logic [6:0]      offset_q, offset_d;
  logic            offset_vld_q, offset_vld_d;
  logic            locked_q, locked_d;
  logic [7:0]      loss_cnt_q, loss_cnt_d;

  logic            hdr_bad;
  logic            go_restart;
  logic            count_loss;

  assign hdr_bad = (hdr_i == 2'b00) || (hdr_i == 2'b11);

  // Next-state and next-output logic; every output is registered so
  // transitions appear the cycle after the triggering edge.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    hdr_cnt_d    = hdr_cnt_q;
    good_cnt_d   = good_cnt_q;
    win_cnt_d    = win_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    seeker_rst_d = seeker_rst_q;
    offset_d     = offset_q;
    offset_vld_d = offset_vld_q;
    locked_d     = locked_q;
    loss_cnt_d   = loss_cnt_q;
    go_restart   = 1'b0;
    count_loss   = 1'b0;

    unique case (state_q)
      // Hold the seeker in reset for a fixed number of clocks; relock
      // requests are ignored here and do not stretch the count.
      ST_RESTART: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d      = ST_SEARCH;
          seeker_rst_d = 1'b0;
          hdr_cnt_d    = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end

      // Let the seeker converge, then freeze its offset if it is legal.
      ST_SEARCH: begin
        if (relock_req_i) begin
          go_restart = 1'b1;
        end else if (hdr_dv_i) begin
          if (hdr_cnt_q == SETTLE_LAST) begin
            if (seek_offset_i > OFFSET_MAX) begin
              go_restart = 1'b1;
            end else begin
              offset_d     = seek_offset_i;
              offset_vld_d = 1'b1;
              good_cnt_d   = '0;
              state_d      = ST_VERIFY;
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + HW'(1);
          end
        end
      end

      // Any bad header at the frozen offset means the seeker was wrong.
      ST_VERIFY: begin
        if (relock_req_i) begin
          go_restart = 1'b1;
        end else if (hdr_dv_i) begin
          if (hdr_bad) begin
            go_restart = 1'b1;
          end else if (good_cnt_q == GOOD_LAST) begin
            locked_d  = 1'b1;
            win_cnt_d = '0;
            bad_cnt_d = '0;
            state_d   = ST_LOCKED;
          end else begin
            good_cnt_d = good_cnt_q + GW'(1);
          end
        end
      end

      // Loss is checked before the window wrap so a threshold hit on the
      // last header of a window still drops lock.
      ST_LOCKED: begin
        if (relock_req_i) begin
          go_restart = 1'b1;
          count_loss = 1'b1;
        end else if (hdr_dv_i) begin
          if (hdr_bad && (bad_cnt_q == BAD_LAST)) begin
            go_restart = 1'b1;
            count_loss = 1'b1;
          end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            bad_cnt_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WW'(1);
            if (hdr_bad) begin
              bad_cnt_d = bad_cnt_q + BW'(1);
            end
          end
        end
      end

      default: go_restart = 1'b1;
    endcase

    // Common entry into RESTART; offset_o keeps its last captured value.
    if (go_restart) begin
      state_d      = ST_RESTART;
      rst_cnt_d    = '0;
      seeker_rst_d = 1'b1;
      offset_vld_d = 1'b0;
      locked_d     = 1'b0;
    end

    if (count_loss && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RESTART;
      rst_cnt_q    <= '0;
      hdr_cnt_q    <= '0;
      good_cnt_q   <= '0;
      win_cnt_q    <= '0;
      bad_cnt_q    <= '0;
      seeker_rst_q <= 1'b1;
      offset_q     <= '0;
      offset_vld_q <= 1'b0;
      locked_q     <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      hdr_cnt_q    <= hdr_cnt_d;
      good_cnt_q   <= good_cnt_d;
      win_cnt_q    <= win_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      seeker_rst_q <= seeker_rst_d;
      offset_q     <= offset_d;
      offset_vld_q <= offset_vld_d;
      locked_q     <= locked_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  assign seeker_rst_o    = seeker_rst_q;
  assign offset_o        = offset_q;
  assign offset_vld_o    = offset_vld_q;
  assign locked_o        = locked_q;
  assign lock_loss_cnt_o = loss_cnt_q;

endmodule

// File: tb/tb_block_lock_ctrl.sv
// tb_block_lock_ctrl: scoreboard bench for block_lock_ctrl.
// Each driven cycle runs a behavioural model whose expected outputs are
// queued and compared against the DUT on the following falling edge.
// Directed checks mark the key points of each scenario.
module tb_block_lock_ctrl;

  localparam int RST_CYCLES  = 4;
  localparam int SETTLE_HDRS = 64;
  localparam int LOCK_GOOD   = 32;
  localparam int WIN_SIZE    = 64;
  localparam int BAD_MAX     = 16;

  localparam int S_RESTART = 0;
  localparam int S_SEARCH  = 1;
  localparam int S_VERIFY  = 2;
  localparam int S_LOCKED  = 3;

  logic       clk_i;
  logic       rst_ni;
  logic [6:0] seek_off;
  logic [1:0] d_hdr;
  logic       d_dv;
  logic       d_rq;
  logic       seeker_rst_o;
  logic [6:0] offset_o;
  logic       offset_vld_o;
  logic       locked_o;
  logic [7:0] lock_loss_cnt_o;

  typedef struct packed {
    logic       srst;
    logic [6:0] off;
    logic       vld;
    logic       lock;
    logic [7:0] loss;
  } exp_t;

  exp_t sb[$];
  exp_t mon_exp;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int         m_state;
  int         m_rcnt, m_hcnt, m_good, m_win, m_bad;
  logic       e_srst, e_vld, e_lock;
  logic [6:0] e_off;
  logic [7:0] e_loss;

  block_lock_ctrl #(
    .RST_CYCLES (RST_CYCLES),
    .SETTLE_HDRS(SETTLE_HDRS),
    .LOCK_GOOD  (LOCK_GOOD),
    .WIN_SIZE   (WIN_SIZE),
    .BAD_MAX    (BAD_MAX)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .seek_offset_i  (seek_off),
    .hdr_i          (d_hdr),
    .hdr_dv_i       (d_dv),
    .relock_req_i   (d_rq),
    .seeker_rst_o   (seeker_rst_o),
    .offset_o       (offset_o),
    .offset_vld_o   (offset_vld_o),
    .locked_o       (locked_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_state = S_RESTART;
    m_rcnt = 0; m_hcnt = 0; m_good = 0; m_win = 0; m_bad = 0;
    e_srst = 1'b1; e_off = '0; e_vld = 1'b0; e_lock = 1'b0; e_loss = '0;
  endtask

  task automatic model_restart(input bit loss);
    m_state = S_RESTART;
    m_rcnt  = 0;
    e_srst  = 1'b1;
    e_vld   = 1'b0;
    e_lock  = 1'b0;
    if (loss && e_loss != 8'd255) e_loss = e_loss + 8'd1;
  endtask

  task automatic model_edge(input logic dv, input logic [1:0] hdr, input logic rq);
    bit bad;
    bad = (hdr == 2'b00) || (hdr == 2'b11);
    case (m_state)
      S_RESTART: begin
        m_rcnt++;
        if (m_rcnt == RST_CYCLES) begin
          m_state = S_SEARCH;
          m_hcnt  = 0;
          e_srst  = 1'b0;
        end
      end
      S_SEARCH: begin
        if (rq) model_restart(0);
        else if (dv) begin
          m_hcnt++;
          if (m_hcnt == SETTLE_HDRS) begin
            if (seek_off > 7'd65) model_restart(0);
            else begin
              e_off   = seek_off;
              e_vld   = 1'b1;
              m_good  = 0;
              m_state = S_VERIFY;
            end
          end
        end
      end
      S_VERIFY: begin
        if (rq) model_restart(0);
        else if (dv) begin
          if (bad) model_restart(0);
          else begin
            m_good++;
            if (m_good == LOCK_GOOD) begin
              e_lock  = 1'b1;
              m_win   = 0;
              m_bad   = 0;
              m_state = S_LOCKED;
            end
          end
        end
      end
      default: begin
        if (rq) model_restart(1);
        else if (dv) begin
          m_win++;
          if (bad) m_bad++;
          if (m_bad == BAD_MAX) model_restart(1);
          else if (m_win == WIN_SIZE) begin
            m_win = 0;
            m_bad = 0;
          end
        end
      end
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic dv, input logic [1:0] hdr, input logic rq);
    d_dv  = dv;
    d_hdr = hdr;
    d_rq  = rq;
    @(posedge clk_i);
    model_edge(dv, hdr, rq);
    sb.push_back('{srst: e_srst, off: e_off, vld: e_vld, lock: e_lock, loss: e_loss});
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b01, 1'b0);
  endtask

  task automatic goods(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
  endtask

  // Scoreboard monitor: outputs are stable at the falling edge.
  always @(negedge clk_i) begin
    while (sb.size() > 0) begin
      mon_exp = sb.pop_front();
      check("sb_seeker_rst", int'(seeker_rst_o),    int'(mon_exp.srst));
      check("sb_offset",     int'(offset_o),        int'(mon_exp.off));
      check("sb_offset_vld", int'(offset_vld_o),    int'(mon_exp.vld));
      check("sb_locked",     int'(locked_o),        int'(mon_exp.lock));
      check("sb_loss_cnt",   int'(lock_loss_cnt_o), int'(mon_exp.loss));
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_srst"},   int'(seeker_rst_o),    1);
    check({tag, "_offset"}, int'(offset_o),        0);
    check({tag, "_vld"},    int'(offset_vld_o),    0);
    check({tag, "_locked"}, int'(locked_o),        0);
    check({tag, "_loss"},   int'(lock_loss_cnt_o), 0);
  endtask

  // Watchdog: the stimulus is fixed-length, so this only fires on a hang.
  initial begin
    #500us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst_ni   = 1'b0;
    seek_off = 7'd23;
    d_dv     = 1'b0;
    d_hdr    = 2'b01;
    d_rq     = 1'b0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    check_reset_vals("rst_hold");

    // T1: seeker reset held for RST_CYCLES cycles after release
    rst_ni = 1'b1;
    cnt = seeker_rst_o ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 2'b01, 1'b0);
      if (seeker_rst_o) cnt++;
    end
    check("t1_srst_cycles", cnt, RST_CYCLES);
    check("t1_locked", int'(locked_o), 0);

    // T2: clean stream, offset 23 frozen, then lock
    goods(SETTLE_HDRS);
    check("t2_offset", int'(offset_o), 23);
    check("t2_vld", int'(offset_vld_o), 1);
    check("t2_not_locked", int'(locked_o), 0);
    goods(LOCK_GOOD - 1);
    check("t2_pre_lock", int'(locked_o), 0);
    goods(1);
    check("t2_locked", int'(locked_o), 1);

    // T4: three windows with 15 bad each, offset moves meanwhile (ignored)
    seek_off = 7'd40;
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < WIN_SIZE; i++)
        cyc(1'b1, (i % 4 == 0 && i < 60) ? 2'b11 : 2'b10, 1'b0);
    check("t4_still_locked", int'(locked_o), 1);
    check("t4_offset_frozen", int'(offset_o), 23);
    check("t4_no_loss", int'(lock_loss_cnt_o), 0);
    for (int i = 0; i < BAD_MAX; i++) cyc(1'b1, 2'b00, 1'b0);
    check("t4_lost", int'(locked_o), 0);
    check("t4_loss_cnt", int'(lock_loss_cnt_o), 1);
    idle(RST_CYCLES);

    // T3: 31 good in VERIFY then a bad header
    seek_off = 7'd23;
    goods(SETTLE_HDRS);
    goods(LOCK_GOOD - 1);
    cyc(1'b1, 2'b11, 1'b0);
    check("t3_locked", int'(locked_o), 0);
    check("t3_vld", int'(offset_vld_o), 0);
    check("t3_loss_cnt", int'(lock_loss_cnt_o), 1);
    cnt = seeker_rst_o ? 1 : 0;
    for (int i = 0; i < RST_CYCLES; i++) begin
      cyc(1'b0, 2'b01, 1'b0);
      if (seeker_rst_o) cnt++;
    end
    check("t3_srst_cycles", cnt, RST_CYCLES);

    // Out-of-range seeker offset at capture: re-search, nothing captured
    seek_off = 7'd70;
    goods(SETTLE_HDRS);
    check("inv_vld", int'(offset_vld_o), 0);
    check("inv_srst", int'(seeker_rst_o), 1);
    check("inv_offset_kept", int'(offset_o), 23);
    idle(RST_CYCLES);

    // T5: 16th bad header is the 64th of its window -> loss wins
    seek_off = 7'd5;
    goods(SETTLE_HDRS + LOCK_GOOD);
    check("t5_locked", int'(locked_o), 1);
    check("t5_offset", int'(offset_o), 5);
    for (int i = 0; i < WIN_SIZE; i++)
      cyc(1'b1, (i >= WIN_SIZE - BAD_MAX) ? 2'b11 : 2'b01, 1'b0);
    check("t5_lost", int'(locked_o), 0);
    check("t5_loss_cnt", int'(lock_loss_cnt_o), 2);
    idle(RST_CYCLES);

    // T6a: relock pulse while LOCKED counts as a loss
    goods(SETTLE_HDRS + LOCK_GOOD);
    check("t6_locked", int'(locked_o), 1);
    cyc(1'b0, 2'b01, 1'b1);
    check("t6_relock_unlock", int'(locked_o), 0);
    check("t6_relock_loss", int'(lock_loss_cnt_o), 3);
    // Request held in RESTART does not stretch the seeker reset
    for (int i = 0; i < RST_CYCLES - 1; i++) cyc(1'b0, 2'b01, 1'b1);
    cyc(1'b0, 2'b01, 1'b0);
    check("t6_no_stretch", int'(seeker_rst_o), 0);

    // T6b: asynchronous reset mid-VERIFY
    goods(SETTLE_HDRS + 10);
    check("t6_verify_vld", int'(offset_vld_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_vals("t6_async");
    @(negedge clk_i);
    check_reset_vals("t6_async_hold");
    rst_ni = 1'b1;
    model_reset();
    idle(RST_CYCLES + 2);
    check("t6_post_srst", int'(seeker_rst_o), 0);

    #1;
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
